torus_router_buffered: RTL and testbench

- Parametrised 5-port 2D-torus router for the mesh/torus NoC top: buffered, arbitrated successor of the current unbuffered router.
- Per-input FIFOs, shortest-path dimension-order routing with torus wrap-around, round-robin output arbitration, and valid/ready backpressure.
- Handles any X_SIZE/Y_SIZE, flit width and buffer depth. Instantiated once per grid node by the NoC top.

---
 rtl/noc_pkg.sv | 83 ++++++++
 rtl/flit_fifo.sv | 70 +++++++
 rtl/torus_router_buffered.sv | 146 ++++++++++++++
 tb/tb_torus_router_buffered.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port numbering, coordinate widths, torus routing
// and the round-robin pick used by every output arbiter.
package noc_pkg;

  localparam int NPORTS = 5;

  localparam logic [2:0] PORT_CORE  = 3'd0;
  localparam logic [2:0] PORT_UP    = 3'd1;
  localparam logic [2:0] PORT_DOWN  = 3'd2;
  localparam logic [2:0] PORT_RIGHT = 3'd3;
  localparam logic [2:0] PORT_LEFT  = 3'd4;

  // Grid coordinate pair, wide enough for any practical grid dimension.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } coord_t;

  // Result of a round-robin search: whether anything was found, and where.
  typedef struct packed {
    logic       any;
    logic [2:0] idx;
  } pick_t;

  // Width of one coordinate field; a 1-wide grid still carries a 1-bit field.
  function automatic int coord_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Forward distance (dest - here) mod size. Adding size first keeps the
  // intermediate non-negative; one conditional subtract folds it back.
  function automatic logic [16:0] torus_dist(input logic [15:0] dest,
                                             input logic [15:0] here,
                                             input logic [15:0] size);
    logic [16:0] d;
    d = {1'b0, dest} + {1'b0, size} - {1'b0, here};
    if (d >= {1'b0, size}) d = d - {1'b0, size};
    return d;
  endfunction

  // Dimension-order shortest-path routing: X first, then Y, else deliver.
  // A distance of exactly half the ring goes the positive way (right/down).
  function automatic logic [2:0] torus_route(input coord_t dest,
                                             input coord_t here,
                                             input coord_t size);
    logic [16:0] dx;
    logic [16:0] dy;
    logic [2:0]  port;
    dx = torus_dist(dest.x, here.x, size.x);
    dy = torus_dist(dest.y, here.y, size.y);
    port = PORT_CORE;
    if (dx != '0) begin
      port = (dx <= {2'b00, size.x[15:1]}) ? PORT_RIGHT : PORT_LEFT;
    end else if (dy != '0) begin
      port = (dy <= {2'b00, size.y[15:1]}) ? PORT_DOWN : PORT_UP;
    end
    return port;
  endfunction

  // Port index following p, wrapping after the last port.
  function automatic logic [2:0] rr_next(input logic [2:0] p);
    return (p == 3'(NPORTS - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  // First requester found scanning upward from ptr, wrapping around.
  function automatic pick_t rr_pick(input logic [NPORTS-1:0] req,
                                    input logic [2:0]        ptr);
    pick_t      p;
    logic [2:0] cand;
    p.any = 1'b0;
    p.idx = 3'd0;
    cand  = ptr;
    for (int k = 0; k < NPORTS; k++) begin
      if (!p.any && req[cand]) begin
        p.any = 1'b1;
        p.idx = cand;
      end
      cand = rr_next(cand);
    end
    return p;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Per-input flit FIFO. The head is read asynchronously so the router can
// route and forward a flit on the edge right after it was pushed.
module flit_fifo #(
  parameter int PL    = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [PL-1:0] din,
  output logic [PL-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [PL-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointers and occupancy; simultaneous push and pop keep count.
  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state; reset empties the FIFO so stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/torus_router_buffered.sv
// Buffered 5-port 2D-torus router: per-input FIFOs, dimension-order
// shortest-path routing with wrap-around, round-robin output arbitration
// and one output register per port with valid/ready flow control.
// Header layout: dest_y in bits [YW-1:0], dest_x in bits [YW+XW-1:YW].
module torus_router_buffered
  import noc_pkg::*;
#(
  parameter int X_SIZE = 4,
  parameter int Y_SIZE = 4,
  parameter int PL     = 32,
  parameter int DEPTH  = 4,
  localparam int XW    = coord_w(X_SIZE),
  localparam int YW    = coord_w(Y_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [XW-1:0]                router_X,
  input  logic [YW-1:0]                router_Y,
  input  logic [NPORTS-1:0][PL-1:0]    in_data,
  input  logic [NPORTS-1:0]            in_valid,
  output logic [NPORTS-1:0]            in_ready,
  output logic [NPORTS-1:0][PL-1:0]    out_data,
  output logic [NPORTS-1:0]            out_valid,
  input  logic [NPORTS-1:0]            out_ready,
  output logic                         err_dest
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [NPORTS-1:0][PL-1:0]     head_data;
  logic [NPORTS-1:0]             head_valid;
  logic [NPORTS-1:0]             head_bad;
  logic [NPORTS-1:0][2:0]        head_port;
  logic [NPORTS-1:0]             pop;
  logic [NPORTS-1:0][NPORTS-1:0] req;      // req[output][input]
  logic [NPORTS-1:0]             load;
  logic [NPORTS-1:0][2:0]        gnt_idx;
  logic                          err_q, err_d;

  // Input side: buffer, decode the head and route it.
  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_in
    logic              full, empty;
    logic [CW-1:0]     count;
    logic [XW-1:0]     dest_x;
    logic [YW-1:0]     dest_y;
    coord_t            dest, here, size;
    logic [NPORTS-1:0] served;

    flit_fifo #(.PL(PL), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid[gi] & ~full),
      .pop   (pop[gi]),
      .din   (in_data[gi]),
      .dout  (head_data[gi]),
      .full  (full),
      .empty (empty),
      .count (count)
    );

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready[gi]   = (count < CW'(DEPTH));
    assign head_valid[gi] = ~empty;

    assign dest_x = head_data[gi][YW+XW-1:YW];
    assign dest_y = head_data[gi][YW-1:0];
    assign dest   = {16'(dest_x), 16'(dest_y)};
    assign here   = {16'(router_X), 16'(router_Y)};
    assign size   = {16'(X_SIZE), 16'(Y_SIZE)};

    // Off-grid destinations are discarded instead of being routed.
    assign head_bad[gi]  = head_valid[gi] &
                           ((32'(dest_x) >= 32'(X_SIZE)) |
                            (32'(dest_y) >= 32'(Y_SIZE)));
    assign head_port[gi] = torus_route(dest, here, size);

    for (genvar go = 0; go < NPORTS; go++) begin : g_req
      assign req[go][gi] = head_valid[gi] & ~head_bad[gi] &
                           (head_port[gi] == 3'(go));
      assign served[go]  = load[go] & (gnt_idx[go] == 3'(gi));
    end

    // A head routes to a single output, so at most one pop per cycle.
    assign pop[gi] = head_bad[gi] | (|served);
  end

  // Output side: round-robin arbiter feeding one output register.
  for (genvar go = 0; go < NPORTS; go++) begin : g_out
    logic [2:0]    ptr_q, ptr_d;
    logic [PL-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    pick_t         pick;

    // Only a grant that actually loads the register counts, so a stalled
    // output does not rotate priority past a waiting input.
    assign pick         = rr_pick(req[go], ptr_q);
    assign load[go]     = pick.any & (~valid_q | out_ready[go]);
    assign gnt_idx[go]  = pick.idx;
    assign out_data[go]  = data_q;
    assign out_valid[go] = valid_q;

    // Next output register and pointer; data is held while stalled.
    always_comb begin
      ptr_d   = ptr_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (load[go]) begin
        ptr_d   = rr_next(pick.idx);
        data_d  = head_data[pick.idx];
        valid_d = 1'b1;
      end else if (out_ready[go]) begin
        valid_d = 1'b0;
      end
    end

    // Output register and arbitration pointer.
    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_q   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        ptr_q   <= ptr_d;
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_comb begin
    err_d = err_q | (|head_bad);
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_dest = err_q;

endmodule

// File: tb/tb_torus_router_buffered.sv
// Directed bench for torus_router_buffered: scoreboard of expected flits per
// output, popped by a monitor on every completed output transfer.
module tb_torus_router_buffered;

  localparam int NP = 5;
  localparam int PL = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4x4 instance
  logic [1:0]           rx, ry;
  logic [NP-1:0][PL-1:0] in_data, out_data;
  logic [NP-1:0]        in_valid, in_ready, out_valid, out_ready;
  logic                 err_dest;

  // 3x4 instance for out-of-range destinations
  logic [1:0]           rx3, ry3;
  logic [NP-1:0][PL-1:0] in_data3, out_data3;
  logic [NP-1:0]        in_valid3, in_ready3, out_valid3, out_ready3;
  logic                 err_dest3;

  int checks   = 0;
  int failures = 0;

  logic [PL-1:0] exp_q [NP][$];

  int t2x [4] = '{3, 2, 0, 0};
  int t2y [4] = '{0, 0, 3, 2};
  int t2p [4] = '{4, 3, 1, 2};

  torus_router_buffered #(.X_SIZE(4), .Y_SIZE(4), .PL(PL), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .router_X(rx), .router_Y(ry),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_dest(err_dest)
  );

  torus_router_buffered #(.X_SIZE(3), .Y_SIZE(4), .PL(PL), .DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .router_X(rx3), .router_Y(ry3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .err_dest(err_dest3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PL-1:0] mk(input int x, input int y, input int tag);
    return {tag[27:0], x[1:0], y[1:0]};
  endfunction

  // Independent reference: signed difference folded into [0, size).
  function automatic int ref_port(input int tx, input int ty, input int hx,
                                  input int hy, input int sx, input int sy);
    int ddx, ddy;
    ddx = tx - hx;
    if (ddx < 0) ddx += sx;
    ddy = ty - hy;
    if (ddy < 0) ddy += sy;
    if (ddx != 0) return (ddx <= sx / 2) ? 3 : 4;
    if (ddy != 0) return (ddy <= sy / 2) ? 2 : 1;
    return 0;
  endfunction

  // Inject core-bound flits on the ports in mask in one cycle, then drain.
  task automatic inject(input logic [NP-1:0] mask, input int tagbase);
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) in_data[p] = mk(1, 1, tagbase + p);
    end
    in_valid = mask;
    tick();
    in_valid = '0;
    repeat (5) tick();
  endtask

  // Scoreboard monitor: one line per completed output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        if (out_valid[p] && out_ready[p]) begin
          chk($sformatf("out%0d_expected", p), 64'(exp_q[p].size() != 0), 64'd1);
          if (exp_q[p].size() != 0) begin
            chk($sformatf("out%0d_data", p), 64'(out_data[p]), 64'(exp_q[p].pop_front()));
            $display("xfer port=%0d data=0x%08h", p, out_data[p]);
          end
        end
      end
    end
  end

  initial begin
    logic [PL-1:0] f, f0;
    int            accepted;

    in_data = '0; in_valid = '0; out_ready = '1; rx = 2'd0; ry = 2'd0;
    in_data3 = '0; in_valid3 = '0; out_ready3 = '1; rx3 = 2'd0; ry3 = 2'd0;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(|out_data), 64'd0);
    chk("rst_err", 64'(err_dest), 64'd0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", 64'(in_ready), 64'h1f);

    // 1: local delivery, one-cycle latency
    rx = 2'd1; ry = 2'd1;
    f = mk(1, 1, 'h00ABCD);
    in_data[0] = f; in_valid[0] = 1'b1;
    exp_q[0].push_back(f);
    tick();
    in_valid[0] = 1'b0;
    chk("t1_not_early", 64'(out_valid), 64'd0);
    tick();
    chk("t1_out_valid", 64'(out_valid), 64'b00001);
    chk("t1_out_data", 64'(out_data[0]), 64'(f));
    repeat (2) tick();

    // 2: direction choice at node (0,0), including the half-ring tie
    rx = 2'd0; ry = 2'd0;
    for (int i = 0; i < 4; i++) begin
      f = mk(t2x[i], t2y[i], 16 + i);
      in_data[0] = f; in_valid[0] = 1'b1;
      exp_q[t2p[i]].push_back(f);
      tick();
      in_valid[0] = 1'b0;
      tick();
      chk($sformatf("t2_route_%0d", i), 64'(out_valid), 64'(1) << t2p[i]);
    end
    repeat (2) tick();

    // Sweep every destination from node (1,1), streamed back-to-back
    rx = 2'd1; ry = 2'd1;
    for (int d = 0; d < 16; d++) begin
      f = mk(d / 4, d % 4, 'h40 + d);
      in_data[0] = f; in_valid[0] = 1'b1;
      exp_q[ref_port(d / 4, d % 4, 1, 1, 4, 4)].push_back(f);
      tick();
    end
    in_valid[0] = 1'b0;
    repeat (4) tick();

    // 3: round-robin at the core output
    exp_q[0].push_back(mk(1, 1, 'h101));
    exp_q[0].push_back(mk(1, 1, 'h103));
    exp_q[0].push_back(mk(1, 1, 'h104));
    for (int p = 0; p < NP; p++) in_data[p] = mk(1, 1, 'h100 + p);
    in_valid = 5'b11010;
    tick();
    in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3_busy_%0d", k), 64'(out_valid[0]), 64'd1);
    end
    tick();
    chk("t3_idle", 64'(out_valid[0]), 64'd0);
    repeat (2) tick();

    exp_q[0].push_back(mk(1, 1, 'h201));
    exp_q[0].push_back(mk(1, 1, 'h203));
    exp_q[0].push_back(mk(1, 1, 'h204));
    inject(5'b11010, 'h200);
    exp_q[0].push_back(mk(1, 1, 'h301));      // moves pointer to 2
    inject(5'b00010, 'h300);
    exp_q[0].push_back(mk(1, 1, 'h400));      // search from 2 reaches 0 first
    exp_q[0].push_back(mk(1, 1, 'h401));
    inject(5'b00011, 'h400);
    exp_q[0].push_back(mk(1, 1, 'h503));      // pointer at 2: 3 beats 1
    exp_q[0].push_back(mk(1, 1, 'h501));
    inject(5'b01010, 'h500);

    // 4: backpressure on the right output
    out_ready[3] = 1'b0;
    accepted = 0;
    f0 = mk(2, 1, 'h600);
    for (int i = 0; i < 10; i++) begin
      f = mk(2, 1, 'h600 + accepted);
      in_data[0] = f; in_valid[0] = 1'b1;
      if (in_ready[0]) begin
        exp_q[3].push_back(f);
        accepted++;
      end
      tick();
    end
    in_valid[0] = 1'b0;
    chk("t4_accepted", 64'(accepted), 64'd5);
    chk("t4_in_ready_low", 64'(in_ready[0]), 64'd0);
    chk("t4_hold_valid", 64'(out_valid[3]), 64'd1);
    chk("t4_hold_data", 64'(out_data[3]), 64'(f0));
    out_ready[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_drain_%0d", k), 64'(out_valid[3]), 64'd1);
      tick();
    end
    chk("t4_drained", 64'(out_valid[3]), 64'd0);
    chk("t4_in_ready_back", 64'(in_ready[0]), 64'd1);

    // 5: out-of-range destination on the 3-wide grid
    f = mk(3, 0, 'h55);
    in_data3[0] = f; in_valid3[0] = 1'b1;
    tick();
    in_valid3[0] = 1'b0;
    chk("t5_err_not_yet", 64'(err_dest3), 64'd0);
    tick();
    chk("t5_err_set", 64'(err_dest3), 64'd1);
    chk("t5_no_out", 64'(out_valid3), 64'd0);
    repeat (3) tick();
    chk("t5_err_sticky", 64'(err_dest3), 64'd1);
    chk("t5_no_out_later", 64'(out_valid3), 64'd0);
    chk("t5_fifo_freed", 64'(in_ready3), 64'h1f);
    f = mk(2, 0, 'h66);
    in_data3[0] = f; in_valid3[0] = 1'b1;
    tick();
    in_valid3[0] = 1'b0;
    tick();
    chk("t5_legal_port", 64'(out_valid3), 64'b10000);
    chk("t5_legal_data", 64'(out_data3[4]), 64'(f));
    repeat (2) tick();
    chk("no_err_4x4", 64'(err_dest), 64'd0);

    // 6: reset with flits buffered; none may ever appear
    out_ready = '0;
    for (int i = 0; i < 4; i++) begin
      in_data[0] = mk(1, 1, 'h700 + i); in_valid[0] = 1'b1;
      tick();
    end
    in_valid[0] = 1'b0;
    chk("t6_buffered", 64'(out_valid[0]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'h1f);
    chk("t6_err", 64'(err_dest), 64'd0);
    chk("t6_err3", 64'(err_dest3), 64'd0);
    out_ready = '1;
    repeat (6) tick();
    chk("t6_never_appear", 64'(out_valid), 64'd0);

    for (int p = 0; p < NP; p++) begin
      chk($sformatf("end_queue%0d_empty", p), 64'(exp_q[p].size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
